// File: rtl/usb_sie_tx.sv
// Transmit half of the USB low-speed SIE: frames PID, payload and CRC16 onto the
// transceiver byte port.
module usb_sie_tx #(
    parameter int unsigned MaxPayload = 8
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [3:0] req_pid_i,
    input  logic [3:0] req_len_i,
    input  logic [7:0] pl_data_i,
    input  logic       pl_valid_i,
    output logic       pl_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       err_o
);

    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidNak   = 4'b1010;
    localparam logic [3:0] PidStall = 4'b1110;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;
    localparam logic [3:0] MaxLen   = 4'(MaxPayload);

    typedef enum logic [2:0] {StIdle, StPid, StData, StCrcLo, StCrcHi, StEop} state_e;

    state_e      state_q, state_d;
    logic [3:0]  pid_q, pid_d;
    logic [3:0]  cnt_q, cnt_d;    // payload bytes still to be fetched
    logic [15:0] crc_q, crc_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        err_q, err_d;

    logic req_is_data, req_is_hs, req_ok, pid_is_data, fetch;

    // Reflected CRC16 (poly 0x8005 -> 0xA001), one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
            else                c = c >> 1;
        end
        return c;
    endfunction

    assign req_is_data = (req_pid_i == PidData0) || (req_pid_i == PidData1);
    assign req_is_hs   = (req_pid_i == PidAck) || (req_pid_i == PidNak) ||
                         (req_pid_i == PidStall);
    assign req_ok      = req_is_hs || (req_is_data && (req_len_i <= MaxLen));
    assign pid_is_data = (pid_q == PidData0) || (pid_q == PidData1);

    // Next-state, datapath and handshake outputs.
    always_comb begin
        state_d     = state_q;
        pid_d       = pid_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        tx_data_d   = tx_data_q;
        err_d       = 1'b0;
        req_ready_o = 1'b0;
        pl_ready_o  = 1'b0;
        tx_valid_o  = 1'b0;
        fetch       = 1'b0;
        case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    pid_d = req_pid_i;
                    cnt_d = req_is_data ? req_len_i : 4'd0;
                    crc_d = 16'hFFFF;
                    if (req_ok) begin
                        state_d   = StPid;
                        tx_data_d = {~req_pid_i, req_pid_i};
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StPid: begin
                tx_valid_o = 1'b1;
                if (tx_ready_i) begin
                    if (!pid_is_data) begin
                        state_d = StEop;
                    end else if (cnt_q == 4'd0) begin
                        state_d   = StCrcLo;
                        tx_data_d = ~crc_q[7:0];
                    end else begin
                        fetch = 1'b1;
                    end
                end
            end
            StData: begin
                tx_valid_o = 1'b1;
                if (tx_ready_i) begin
                    if (cnt_q == 4'd0) begin
                        state_d   = StCrcLo;
                        tx_data_d = ~crc_q[7:0];
                    end else begin
                        fetch = 1'b1;
                    end
                end
            end
            StCrcLo: begin
                tx_valid_o = 1'b1;
                if (tx_ready_i) begin
                    state_d   = StCrcHi;
                    tx_data_d = ~crc_q[15:8];
                end
            end
            StCrcHi: begin
                tx_valid_o = 1'b1;
                if (tx_ready_i) state_d = StEop;
            end
            StEop:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Payload is pulled in the same cycle the previous byte is taken; a missing byte
        // truncates the packet and the host rejects it on CRC.
        if (fetch) begin
            pl_ready_o = 1'b1;
            if (pl_valid_i) begin
                state_d   = StData;
                tx_data_d = pl_data_i;
                crc_d     = crc16_byte(crc_q, pl_data_i);
                cnt_d     = cnt_q - 4'd1;
            end else begin
                state_d = StEop;
                err_d   = 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= StIdle;
            pid_q     <= 4'd0;
            cnt_q     <= 4'd0;
            crc_q     <= 16'hFFFF;
            tx_data_q <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pid_q     <= pid_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
        end
    end

    assign tx_data_o = tx_data_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_usb_sie_tx.sv
// Bench for usb_sie_tx: two instances (MaxPayload 8 and 9) behind a select mux,
// table-driven packets with a byte scoreboard, plus hand-written reset sequences.
module tb_usb_sie_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n   = 1'b0;
    logic       sel       = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_pid   = 4'd0;
    logic [3:0] req_len   = 4'd0;
    logic [7:0] pl_data   = 8'h00;
    logic       pl_valid  = 1'b0;
    logic       tx_ready  = 1'b0;

    logic       req_valid8, req_ready8, pl_ready8, tx_valid8, err8;
    logic       req_valid9, req_ready9, pl_ready9, tx_valid9, err9;
    logic [7:0] tx_data8, tx_data9;
    logic       req_ready, pl_ready, tx_valid, err;
    logic [7:0] tx_data;

    assign req_valid8 = req_valid & ~sel;
    assign req_valid9 = req_valid & sel;
    assign req_ready  = sel ? req_ready9 : req_ready8;
    assign pl_ready   = sel ? pl_ready9  : pl_ready8;
    assign tx_valid   = sel ? tx_valid9  : tx_valid8;
    assign err        = sel ? err9       : err8;
    assign tx_data    = sel ? tx_data9   : tx_data8;

    usb_sie_tx #(.MaxPayload(8)) u_dut8 (
        .clk_i(clk), .reset_ni(reset_n), .req_valid_i(req_valid8), .req_ready_o(req_ready8),
        .req_pid_i(req_pid), .req_len_i(req_len), .pl_data_i(pl_data), .pl_valid_i(pl_valid),
        .pl_ready_o(pl_ready8), .tx_data_o(tx_data8), .tx_valid_o(tx_valid8),
        .tx_ready_i(tx_ready), .err_o(err8)
    );

    usb_sie_tx #(.MaxPayload(9)) u_dut9 (
        .clk_i(clk), .reset_ni(reset_n), .req_valid_i(req_valid9), .req_ready_o(req_ready9),
        .req_pid_i(req_pid), .req_len_i(req_len), .pl_data_i(pl_data), .pl_valid_i(pl_valid),
        .pl_ready_o(pl_ready9), .tx_data_o(tx_data9), .tx_valid_o(tx_valid9),
        .tx_ready_i(tx_ready), .err_o(err9)
    );

    typedef struct {
        logic       sel;
        logic [3:0] pid;
        logic [3:0] len;
        logic [7:0] base;
        logic [7:0] step;
        int         period;
        int         drop_at;
        int         exp_bytes;
        int         exp_plr;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] payload[16];
    vec_t       vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ payload[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    task automatic run_vec(input vec_t v);
        logic        is_hs, is_data, legal, underrun;
        logic [15:0] crc;
        int n, fetch_idx, n_bytes, n_plr, n_err, n_valid, err_cyc, fail_cyc;
        int last_take, first_low, first_rdy, maxp;
        bit done;
        is_hs   = (v.pid == 4'b0010) || (v.pid == 4'b1010) || (v.pid == 4'b1110);
        is_data = (v.pid == 4'b0011) || (v.pid == 4'b1011);
        maxp    = v.sel ? 9 : 8;
        legal   = is_hs || (is_data && (int'(v.len) <= maxp));
        underrun = legal && is_data && (v.drop_at >= 0) && (v.drop_at < int'(v.len));
        for (int i = 0; i < 16; i++) payload[i] = v.base + 8'(i) * v.step;
        exp_q.delete();
        if (legal) begin
            exp_q.push_back({~v.pid, v.pid});
            if (is_data) begin
                n = underrun ? v.drop_at : int'(v.len);
                for (int i = 0; i < n; i++) exp_q.push_back(payload[i]);
                if (!underrun) begin
                    crc = crc_model(int'(v.len));
                    exp_q.push_back(crc[7:0]);
                    exp_q.push_back(crc[15:8]);
                end
            end
        end
        fetch_idx = 0; n_bytes = 0; n_plr = 0; n_err = 0; n_valid = 0;
        err_cyc = -1; fail_cyc = -1; last_take = -1; first_low = -1; first_rdy = -1;
        done = 1'b0;
        sel = v.sel;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk); #1;
            req_valid = (c == 0);
            req_pid   = v.pid;
            req_len   = v.len;
            tx_ready  = (c > 0) && tx_valid && ((c % v.period) == 0);
            pl_valid  = (fetch_idx != v.drop_at);
            pl_data   = (fetch_idx < 16) ? payload[fetch_idx] : 8'h00;
            #1;
            if (c == 0) check("req_ready_idle", req_ready, 1);
            if (c == 1) begin
                check("tx_valid_t1", tx_valid, legal);
                check("err_t1", err, !legal);
                if (legal) check("pid_byte_t1", tx_data, {~v.pid, v.pid});
            end
            if (tx_valid) n_valid++;
            if (err) begin n_err++; err_cyc = c; end
            if (pl_ready) begin
                n_plr++;
                if (pl_valid) fetch_idx++;
                else fail_cyc = c;
            end
            if (tx_valid && tx_ready) begin
                n_bytes++;
                last_take = c;
                if (exp_q.size() == 0) check("extra_byte", tx_data, 9'h100);
                else check("tx_byte", tx_data, exp_q.pop_front());
            end
            if (c >= 1 && n_valid > 0 && !tx_valid && first_low < 0) first_low = c;
            if (c >= 1 && req_ready && (!legal || first_low >= 0)) begin
                first_rdy = c;
                done = 1'b1;
            end
        end
        req_valid = 1'b0; tx_ready = 1'b0; pl_valid = 1'b0;
        check("packet_done", done, 1);
        check("byte_count", n_bytes, v.exp_bytes);
        check("pl_ready_count", n_plr, v.exp_plr);
        check("bytes_left", exp_q.size(), 0);
        check("err_count", n_err, (!legal || underrun) ? 1 : 0);
        if (legal) begin
            check("eop_cycle", first_low, last_take + 1);
            check("req_ready_cycle", first_rdy, last_take + 2);
        end else begin
            check("illegal_no_tx", n_valid, 0);
            check("illegal_err_cycle", err_cyc, 1);
        end
        if (underrun) check("underrun_err_cycle", err_cyc, fail_cyc + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // sel, pid, len, base, step, period, drop_at, exp_bytes, exp_plr
        vecs[0] = '{1'b0, 4'b0010, 4'd0, 8'h00, 8'h00, 8, -1, 1, 0};   // ACK
        vecs[1] = '{1'b0, 4'b0011, 4'd0, 8'h00, 8'h00, 3, -1, 3, 0};   // DATA0 len 0
        vecs[2] = '{1'b1, 4'b1011, 4'd9, 8'h31, 8'h01, 2, -1, 12, 9};  // DATA1 "123456789"
        vecs[3] = '{1'b0, 4'b0011, 4'd9, 8'h10, 8'h01, 1, -1, 0, 0};   // len over max
        vecs[4] = '{1'b0, 4'b0000, 4'd2, 8'h10, 8'h01, 1, -1, 0, 0};   // bad PID
        vecs[5] = '{1'b0, 4'b0011, 4'd4, 8'hB0, 8'h01, 1, 2, 3, 3};    // underrun at 3rd
        vecs[6] = '{1'b0, 4'b1010, 4'd0, 8'h00, 8'h00, 4, -1, 1, 0};   // NAK
        vecs[7] = '{1'b1, 4'b1110, 4'd5, 8'h00, 8'h00, 1, -1, 1, 0};   // STALL, len ignored
        vecs[8] = '{1'b0, 4'b1011, 4'd8, 8'hA5, 8'h3C, 5, -1, 11, 8};  // DATA1 len 8
        vecs[9] = '{1'b1, 4'b0011, 4'd1, 8'h00, 8'h00, 2, -1, 4, 1};   // DATA0 len 1

        // Reset state for both instances.
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0; #1;
        check("rst_tx_valid8", tx_valid, 0);
        check("rst_tx_data8", tx_data, 8'h00);
        check("rst_err8", err, 0);
        sel = 1'b1; #1;
        check("rst_tx_valid9", tx_valid, 0);
        check("rst_tx_data9", tx_data, 8'h00);
        check("rst_err9", err, 0);
        reset_n = 1'b1;
        @(posedge clk); #2;
        check("rst_req_ready9", req_ready, 1);
        sel = 1'b0; #1;
        check("rst_req_ready8", req_ready, 1);

        for (int k = 0; k < 10; k++) run_vec(vecs[k]);

        // Reset in the middle of a DATA1 len 8 payload.
        begin
            int fetch_idx;
            fetch_idx = 0;
            sel = 1'b0;
            for (int i = 0; i < 16; i++) payload[i] = 8'h40 + 8'(i);
            for (int c = 0; c < 100 && fetch_idx < 3; c++) begin
                @(posedge clk); #1;
                req_valid = (c == 0);
                req_pid   = 4'b1011;
                req_len   = 4'd8;
                tx_ready  = (c > 0) && tx_valid && ((c % 2) == 0);
                pl_valid  = 1'b1;
                pl_data   = payload[fetch_idx];
                #1;
                if (pl_ready && pl_valid) fetch_idx++;
            end
            @(posedge clk); #1;
            req_valid = 1'b0; tx_ready = 1'b0;
            #1;
            check("mid_tx_valid_before_reset", tx_valid, 1);
            reset_n = 1'b0;
            @(posedge clk); #2;
            check("mid_rst_tx_valid", tx_valid, 0);
            check("mid_rst_err", err, 0);
            check("mid_rst_tx_data", tx_data, 8'h00);
            @(posedge clk); #1;
            reset_n = 1'b1;
            @(posedge clk); #2;
            check("mid_rst_err_after", err, 0);
            check("mid_rst_req_ready", req_ready, 1);
        end
        run_vec('{1'b0, 4'b1010, 4'd0, 8'h00, 8'h00, 3, -1, 1, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_sie_tx.md
# usb_sie_tx

Transmit half of the USB low-speed serial interface engine. Accepts one packet request at a time (handshake PID or DATA0/DATA1 with payload), frames it as PID byte, payload bytes and CRC16, and streams the bytes to the USB transceiver's `tx_data`/`tx_valid`/`tx_ready` byte port. This block drives the transceiver's transmit byte port.

## Interface
- `MAX_PAYLOAD`, 8, maximum payload bytes per DATA packet (1..15)
- `clk`  in  1  system clock (24 MHz)
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `req_valid`  in  1  packet request
- `req_ready`  out  1  block idle, request accepted when `req_valid & req_ready`
- `req_pid`  in  4  PID: ACK 4'b0010, NAK 4'b1010, STALL 4'b1110, DATA0 4'b0011, DATA1 4'b1011
- `req_len`  in  4  payload length for DATA PIDs (0..MAX_PAYLOAD), ignored otherwise
- `pl_data`  in  8  payload byte
- `pl_valid`  in  1  payload byte available
- `pl_ready`  out  1  payload byte consumed this cycle (when `pl_valid & pl_ready`)
- `tx_data`  out  8  byte to transceiver
- `tx_valid`  out  1  rise: SYNC, high: send bytes, fall: EOP
- `tx_ready`  in  1  one-cycle pulse: current `tx_data` byte has been taken
- `err`  out  1  one-cycle pulse: illegal request or payload underrun

## Operation
- States: IDLE, PID, DATA, CRC_LO, CRC_HI, EOP.
- IDLE: `req_ready=1`. On accept, request is latched. Illegal PID or DATA with `req_len>MAX_PAYLOAD` -> `err` pulse next cycle, stay IDLE, nothing sent.
- PID: `tx_data={~pid,pid}`, `tx_valid=1`. On `tx_ready`: handshake PID -> EOP; DATA with len 0 -> CRC_LO; else -> DATA, loading first payload byte.
- DATA: one byte per `tx_ready`; byte count decrements; after the last payload byte is taken -> CRC_LO.
- Payload is fetched in the cycle the preceding byte's `tx_ready` is high: `pl_ready = tx_ready & (next byte is payload)`, combinational. If `pl_valid=0` then -> underrun: `err` pulse, go to EOP (truncated packet; host discards via CRC).
- CRC16: poly 0x8005, init 0xFFFF, LSB-first (reflected) over payload bytes only, result complemented. CRC_LO sends bits [7:0], CRC_HI sends [15:8].
- EOP: `tx_valid=0` for one cycle, then IDLE.
- `tx_ready` while `tx_valid=0` is ignored. `pl_valid` is ignored outside fetch cycles.

## Timing
- Reset (reset=0 at edge): state IDLE, `tx_valid=0`, `tx_data=8'h00`, `err=0`, CRC=0xFFFF, counters 0; `req_ready=1` after reset released. Reset mid-packet: `tx_valid` low at the next edge, packet abandoned, no `err`.
- Accept at cycle T -> `tx_valid=1` with PID byte at T+1.
- `tx_data` is registered: byte changes at the edge following each `tx_ready` pulse, held stable otherwise.
- `tx_ready` for the final byte at cycle N -> `tx_valid=0` at N+1 (EOP), `req_ready=1` at N+2.
- Packet byte count: handshake 1; DATA 3+len.
- `err` for illegal request: cycle T+1. For underrun: the cycle after the failing `tx_ready`.
- CRC update happens in the same edge the payload byte is loaded into `tx_data`; CRC bytes are stable from the load of CRC_LO.

## Test plan
- Request ACK; transceiver model pulses `tx_ready` every 8 cycles -> single byte 8'hD2, `tx_valid` high exactly until the cycle after the first `tx_ready`, `req_ready` back 2 cycles later.
- DATA0, len 0 -> bytes C3 00 00, no `pl_ready` pulses.
- Instance with MAX_PAYLOAD=9, DATA1 with payload ASCII "123456789" -> bytes 4B 31..39 C8 B4 (CRC-16/USB check 0xB4C8), exactly 9 `pl_ready` pulses.
- DATA0 len 9 at MAX_PAYLOAD=8, and `req_pid=4'b0000` -> `err` pulse at T+1 each, `tx_valid` stays 0.
- DATA0 len 4, `pl_valid` drops before the 3rd byte -> bytes C3 b0 b1 then `tx_valid=0`, `err` pulse, next request accepted normally.
- Assert reset during the payload of a DATA1 len 8 -> `tx_valid=0` at next edge, `err=0`, subsequent NAK sends 5A correctly.
